// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall/flush control for the IF/ID and Decode_To_Execute registers.
// Outputs are combinational from FSM state and current inputs; state and statistics counters are registered.
module hazard_stall_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [4:0]             RsDecode,
    input  logic [4:0]             RtDecode,
    input  logic                   UsesRs,
    input  logic                   UsesRt,
    input  logic                   BranchDecode,
    input  logic                   JrDecode,
    input  logic                   JumpDecode,
    input  logic                   RegWriteExecute,
    input  logic [1:0]             MemReadExecute,
    input  logic [4:0]             WriteRegExecute,
    input  logic                   RegWriteMemory,
    input  logic [1:0]             MemReadMemory,
    input  logic [4:0]             WriteRegMemory,
    input  logic                   BranchTaken,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IFIDFlush,
    output logic                   IDEXFlush,
    output logic [STALL_CNT_W-1:0] StallCount,
    output logic [STALL_CNT_W-1:0] FlushCount
);

    typedef enum logic {RUN, STALL} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             stall_left_q, stall_left_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STALL_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       rs_used, rt_used, branch_like, load_e, load_m;
    logic       hit_e, hit_m;
    logic [1:0] need;
    logic       stalling;

    // jr reads Rs in Decode even if the decoder did not flag it
    assign rs_used     = UsesRs | JrDecode;
    assign rt_used     = UsesRt;
    assign branch_like = BranchDecode | JrDecode;
    assign load_e      = (MemReadExecute != 2'd0);
    assign load_m      = (MemReadMemory != 2'd0);

    assign hit_e = RegWriteExecute && (WriteRegExecute != 5'd0) &&
                   ((rs_used && (WriteRegExecute == RsDecode)) ||
                    (rt_used && (WriteRegExecute == RtDecode)));
    assign hit_m = RegWriteMemory && (WriteRegMemory != 5'd0) &&
                   ((rs_used && (WriteRegMemory == RsDecode)) ||
                    (rt_used && (WriteRegMemory == RtDecode)));

    always_comb begin
        need = 2'd0;
        if (load_e && hit_e)
            need = 2'd1;
        if (branch_like && hit_m && load_m)
            need = 2'd1;
        if (branch_like && hit_e)
            need = load_e ? 2'd2 : 2'd1;
    end

    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IFIDFlush    = 1'b0;
        IDEXFlush    = 1'b0;
        stalling     = 1'b0;
        if (BranchTaken) begin
            IFIDFlush    = 1'b1;
            IDEXFlush    = 1'b1;
            state_d      = RUN;
            stall_left_d = 2'd0;
        end else if (state_q == STALL) begin
            stalling     = 1'b1;
            stall_left_d = stall_left_q - 2'd1;
            if (stall_left_d == 2'd0)
                state_d = RUN;
        end else if (need != 2'd0) begin
            stalling = 1'b1;
            if (need == 2'd2) begin
                state_d      = STALL;
                stall_left_d = 2'd1;
            end
        end else if (JumpDecode) begin
            IFIDFlush = 1'b1;
        end
        if (stalling) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    // Statistics counters saturate at all ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stalling && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (IFIDFlush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= RUN;
            stall_left_q <= 2'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized and directed bench for hazard_stall_unit against a cycle-level behavioural model.
module tb_hazard_stall_unit;
    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [4:0]   RsDecode, RtDecode;
    logic         UsesRs, UsesRt, BranchDecode, JrDecode, JumpDecode;
    logic         RegWriteExecute;
    logic [1:0]   MemReadExecute;
    logic [4:0]   WriteRegExecute;
    logic         RegWriteMemory;
    logic [1:0]   MemReadMemory;
    logic [4:0]   WriteRegMemory;
    logic         BranchTaken;
    logic         PCWrite, IFIDWrite, IFIDFlush, IDEXFlush;
    logic [W-1:0] StallCount, FlushCount;

    hazard_stall_unit #(.STALL_CNT_W(W)) dut (
        .Clk(Clk), .Reset(Reset),
        .RsDecode(RsDecode), .RtDecode(RtDecode),
        .UsesRs(UsesRs), .UsesRt(UsesRt),
        .BranchDecode(BranchDecode), .JrDecode(JrDecode), .JumpDecode(JumpDecode),
        .RegWriteExecute(RegWriteExecute), .MemReadExecute(MemReadExecute),
        .WriteRegExecute(WriteRegExecute),
        .RegWriteMemory(RegWriteMemory), .MemReadMemory(MemReadMemory),
        .WriteRegMemory(WriteRegMemory),
        .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: remaining forced stall cycles and the two statistics
    int m_rem = 0;
    int m_sc  = 0;
    int m_fc  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit src_match(input bit we, input logic [4:0] wr, input logic [4:0] r);
        return we && (wr == r) && (r != 0);
    endfunction

    // Longest stall demanded by the hazard rules for the current inputs
    function automatic int required_stall();
        bit rs_u, br, ldE, ldM, hitE, hitM;
        int n;
        rs_u = UsesRs || JrDecode;
        br   = BranchDecode || JrDecode;
        ldE  = MemReadExecute != 0;
        ldM  = MemReadMemory != 0;
        hitE = (rs_u && src_match(RegWriteExecute, WriteRegExecute, RsDecode)) ||
               (UsesRt && src_match(RegWriteExecute, WriteRegExecute, RtDecode));
        hitM = (rs_u && src_match(RegWriteMemory, WriteRegMemory, RsDecode)) ||
               (UsesRt && src_match(RegWriteMemory, WriteRegMemory, RtDecode));
        n = 0;
        if (ldE && hitE) n = 1;
        if (br && hitM && ldM && n < 1) n = 1;
        if (br && hitE && !ldE && n < 1) n = 1;
        if (br && hitE && ldE) n = 2;
        return n;
    endfunction

    task automatic idle_in();
        Reset = 0; RsDecode = 0; RtDecode = 0; UsesRs = 0; UsesRt = 0;
        BranchDecode = 0; JrDecode = 0; JumpDecode = 0;
        RegWriteExecute = 0; MemReadExecute = 0; WriteRegExecute = 0;
        RegWriteMemory = 0; MemReadMemory = 0; WriteRegMemory = 0; BranchTaken = 0;
    endtask

    // Called at a falling edge with inputs set; checks this cycle, then advances to next falling edge
    task automatic step();
        logic [3:0] exp_o;
        int n, nrem;
        bit st, fl;
        #1;
        st = 0; fl = 0; nrem = 0;
        if (BranchTaken) begin
            exp_o = 4'b1111; fl = 1;
        end else if (m_rem > 0) begin
            exp_o = 4'b0001; st = 1; nrem = m_rem - 1;
        end else begin
            n = required_stall();
            if (n > 0) begin
                exp_o = 4'b0001; st = 1; nrem = n - 1;
            end else if (JumpDecode) begin
                exp_o = 4'b1110; fl = 1;
            end else begin
                exp_o = 4'b1100;
            end
        end
        check("outputs", {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}, exp_o);
        check("StallCount", StallCount, m_sc);
        check("FlushCount", FlushCount, m_fc);
        if (Reset) begin
            m_rem = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_rem = nrem;
            if (st && m_sc < 65535) m_sc++;
            if (fl && m_fc < 65535) m_fc++;
        end
        @(negedge Clk);
    endtask

    initial begin
        idle_in();
        Reset = 1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 0;

        // Reset state: idle outputs, zero counters
        step();
        check("reset_StallCount", StallCount, 0);

        // Load-use: one stall cycle
        idle_in(); RegWriteExecute = 1; MemReadExecute = 1; WriteRegExecute = 5;
        RsDecode = 5; UsesRs = 1;
        step();
        idle_in(); step();
        check("loaduse_StallCount", StallCount, 1);

        // Load then beq: two stall cycles, third cycle idle with hazard inputs removed
        idle_in(); RegWriteExecute = 1; MemReadExecute = 1; WriteRegExecute = 7;
        BranchDecode = 1; RtDecode = 7; UsesRt = 1;
        step();
        idle_in(); check("ldbeq_stall2_pcw", {31'd0, PCWrite}, 0);
        step();
        check("ldbeq_idle_pcw", {31'd0, PCWrite}, 1);
        step();
        check("ldbeq_StallCount", StallCount, 3);

        // ALU then jr: exactly one stall
        idle_in(); RegWriteExecute = 1; WriteRegExecute = 31; JrDecode = 1; RsDecode = 31;
        step();
        idle_in(); step();
        check("jr_StallCount", StallCount, 4);

        // $zero is never a hazard
        idle_in(); RegWriteExecute = 1; MemReadExecute = 1; WriteRegExecute = 0;
        UsesRs = 1; BranchDecode = 1;
        step();
        step();
        check("zero_StallCount", StallCount, 4);

        // Flush overrides STALL
        idle_in(); RegWriteExecute = 1; MemReadExecute = 1; WriteRegExecute = 9;
        BranchDecode = 1; RsDecode = 9; UsesRs = 1;
        step();
        idle_in(); BranchTaken = 1;
        step();
        idle_in(); step();
        check("flush_FlushCount", FlushCount, 1);
        check("flush_StallCount", StallCount, 5);

        // Jump flushes only when not stalled
        idle_in(); JumpDecode = 1; step();
        idle_in(); JumpDecode = 1; RegWriteExecute = 1; MemReadExecute = 2;
        WriteRegExecute = 3; UsesRt = 1; RtDecode = 3;
        step();

        // Randomized traffic with small register numbers to provoke matches
        for (int i = 0; i < 3000; i++) begin
            idle_in();
            Reset           = ($urandom_range(63, 0) == 0);
            RsDecode        = 5'($urandom_range(3, 0));
            RtDecode        = 5'($urandom_range(3, 0));
            UsesRs          = 1'($urandom);
            UsesRt          = 1'($urandom);
            BranchDecode    = ($urandom_range(2, 0) == 0);
            JrDecode        = ($urandom_range(4, 0) == 0);
            JumpDecode      = ($urandom_range(4, 0) == 0);
            RegWriteExecute = 1'($urandom);
            MemReadExecute  = 2'($urandom);
            WriteRegExecute = 5'($urandom_range(3, 0));
            RegWriteMemory  = 1'($urandom);
            MemReadMemory   = 2'($urandom);
            WriteRegMemory  = 5'($urandom_range(3, 0));
            BranchTaken     = ($urandom_range(7, 0) == 0);
            step();
        end

        // Saturation: hold a load-use hazard well past 65535 cycles
        idle_in(); Reset = 1; step();
        idle_in(); RegWriteExecute = 1; MemReadExecute = 1; WriteRegExecute = 4;
        RsDecode = 4; UsesRs = 1;
        for (int i = 0; i < 65540; i++) step();
        check("sat_StallCount", StallCount, 16'hFFFF);

        // Reset while in STALL
        idle_in(); RegWriteExecute = 1; MemReadExecute = 1; WriteRegExecute = 6;
        BranchDecode = 1; RsDecode = 6; UsesRs = 1;
        step();
        idle_in(); Reset = 1; step();
        idle_in(); step();
        check("rst_StallCount", StallCount, 0);
        check("rst_FlushCount", FlushCount, 0);
        check("rst_idle_outs", {28'd0, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}, 4'b1100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline control block driving the stall and bubble/flush inputs of the IF/ID and Decode_To_Execute pipeline registers. It compares Decode-stage source registers against destinations held downstream in Execute and Memory, and runs a small stall FSM for multi-cycle load-to-branch hazards. It also issues flushes on taken branches and jumps, and keeps saturating stall and flush statistics counters.

## Interface
- STALL_CNT_W, 16, width of StallCount and FlushCount
- Clk  in  1  pipeline clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- RsDecode, RtDecode  in  5 each  source register fields of the instruction in Decode
- UsesRs, UsesRt  in  1 each  Decode instruction actually reads Rs / Rt
- BranchDecode  in  1  conditional branch in Decode, comparison done in Decode
- JrDecode  in  1  jr in Decode, reads Rs in Decode
- JumpDecode  in  1  j/jal in Decode
- RegWriteExecute  in  1  Execute-stage instruction writes a register
- MemReadExecute  in  2  nonzero = load in Execute
- WriteRegExecute  in  5  destination of the Execute-stage instruction, after RegDst mux
- RegWriteMemory  in  1  Memory-stage instruction writes a register
- MemReadMemory  in  2  nonzero = load in Memory
- WriteRegMemory  in  5  destination of the Memory-stage instruction
- BranchTaken  in  1  branch/jr resolved taken; PC is being redirected this cycle
- PCWrite  out  1  PC enable
- IFIDWrite  out  1  IF/ID register enable
- IFIDFlush  out  1  IF/ID loads a NOP
- IDEXFlush  out  1  Decode_To_Execute loads all-zero controls (bubble)
- StallCount  out  STALL_CNT_W  stalled cycles since reset, saturating
- FlushCount  out  STALL_CNT_W  flush cycles since reset, saturating

## Operation
- Match rules:
  - MatchE(r) = RegWriteExecute && WriteRegExecute==r && r!=0.
  - MatchM(r) = RegWriteMemory && WriteRegMemory==r && r!=0.
  - A source counts only if its Uses* bit is set. JrDecode implies UsesRs.
- Required stall length N, evaluated in RUN only. The largest applicable value wins.
  - Load in Execute (MemReadExecute!=0) matching any used source: N=1.
  - BranchDecode or JrDecode, with MatchE on a used source and no load in Execute: N=1.
  - BranchDecode or JrDecode, with MatchE on a used source and a load in Execute: N=2.
  - BranchDecode or JrDecode, with MatchM on a used source and MemReadMemory!=0: N=1.
  - Otherwise N=0.
- FSM states: RUN, STALL. A 2-bit counter StallLeft holds the remaining stall cycles.
  - RUN with N>0: stall outputs are asserted this cycle. If N==2, the next state is STALL with StallLeft=1. If N==1, the FSM stays in RUN. N==1 hazards naturally re-evaluate clear after the bubble.
  - STALL: stall outputs are asserted and inputs are not re-evaluated. StallLeft decrements each cycle, and the FSM returns to RUN when StallLeft reaches 0.
- Stall outputs: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
- Flush handling has highest priority and overrides any stall in either state.
  - BranchTaken=1: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1. The FSM is forced to RUN with StallLeft=0.
  - Otherwise, JumpDecode=1 with N=0 in RUN: IFIDFlush=1 only.
  - A jump that is stalled is not flushed until its stall clears.
- Idle outputs: PCWrite=1, IFIDWrite=1, both flushes 0.
- Counters:
  - StallCount increments by 1 on every cycle with stall outputs asserted.
  - FlushCount increments on every cycle with IFIDFlush=1.
  - Both hold at all ones and never wrap.

## Timing
- PCWrite, IFIDWrite, IFIDFlush and IDEXFlush are combinational from the FSM state and the current inputs, with no added latency. They must settle before the same rising edge that updates the pipeline registers.
- FSM state and counters are registered.
- Reset outputs: state=RUN, StallLeft=0, StallCount=0, FlushCount=0. The combinational outputs then take their idle values.
- Reset asserted mid-STALL puts the FSM in RUN on the next edge, and the counters clear on that same edge.
- Register 0 is never a hazard, even with RegWrite set.
- If BranchTaken and a hazard occur in the same cycle, the flush wins. The stall is not counted in StallCount, and FlushCount increments.

## Test plan
- Load-use: `lw $5` in Execute (MemReadExecute=1, WriteRegExecute=5); Decode `add` with RsDecode=5, UsesRs=1 -> one cycle of PCWrite=0, IDEXFlush=1; StallCount=1.
- Load then beq: load to $7 in Execute; BranchDecode=1, RtDecode=7 -> 2 stall cycles, FSM passes through STALL; StallCount=2; the third cycle is idle.
- ALU then jr: RegWriteExecute=1, WriteRegExecute=31; JrDecode=1, RsDecode=31 -> exactly 1 stall cycle.
- $zero: load with WriteRegExecute=0 and Decode RsDecode=0 -> no stall; StallCount stays 0.
- Flush priority: assert BranchTaken=1 during STALL -> IFIDFlush=IDEXFlush=PCWrite=1 that cycle, FSM=RUN next cycle; FlushCount increments.
- Saturation and reset: force more than 65535 stall cycles -> StallCount holds 0xFFFF. Assert Reset during STALL -> both counters are 0 on the next edge and outputs are idle.
